// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write port.
// Radix-2 shift-add multiply and restoring divide, one iteration per clock.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    input  logic             i_annul,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_we_hi,
    output logic             o_we_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, DZ} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fin;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    // -2^(W-1) maps onto itself, which is exactly its W-bit unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
        end
    end

    // acc holds {hi, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        op_signed = ~i_op[0];
        abs_a     = mag(i_opa, op_signed);
        abs_b     = mag(i_opb, op_signed);

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (div_part >= {1'b0, opnd_q});
        div_sub  = div_part[WIDTH-1:0] - opnd_q;

        if (is_div_q) begin
            acc_step = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                              : {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_start && !i_annul) begin
                    is_div_d  = i_op[1];
                    neg_res_d = op_signed & (i_opa[WIDTH-1] ^ i_opb[WIDTH-1]);
                    neg_rem_d = op_signed & i_opa[WIDTH-1];
                    opnd_d    = i_op[1] ? abs_b : abs_a;
                    acc_d     = i_op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                    state_d   = (i_op[1] && (i_opb == '0)) ? DZ : RUN;
                end
            end
            RUN: begin
                if (i_annul) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            DZ:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod_fin = neg_res_q ? neg_2w(acc_q) : acc_q;
    end

    // Stall and write enables are combinational so an annul drops them in the same cycle.
    always_comb begin
        o_stall       = 1'b0;
        o_busy        = (state_q != IDLE);
        o_we_hi       = 1'b0;
        o_we_lo       = 1'b0;
        o_hi          = '0;
        o_lo          = '0;
        o_div_by_zero = 1'b0;
        case (state_q)
            IDLE: o_stall = rst & i_start & ~i_annul;
            RUN:  o_stall = ~i_annul;
            DONE: begin
                if (!i_annul) begin
                    o_we_hi = 1'b1;
                    o_we_lo = 1'b1;
                    if (is_div_q) begin
                        o_lo = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                        o_hi = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH])
                                         : acc_q[2*WIDTH-1:WIDTH];
                    end else begin
                        o_hi = prod_fin[2*WIDTH-1:WIDTH];
                        o_lo = prod_fin[WIDTH-1:0];
                    end
                end
            end
            DZ:      o_div_by_zero = ~i_annul;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected HI/LO queued at issue, checked on write pulse.
module tb_hilo_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [1:0]   i_op;
    logic [W-1:0] i_opa;
    logic [W-1:0] i_opb;
    logic         i_annul;
    logic         o_stall;
    logic         o_busy;
    logic         o_we_hi;
    logic         o_we_lo;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;
    logic         o_div_by_zero;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit          dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst_n),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_opa         (i_opa),
        .i_opb         (i_opb),
        .i_annul       (i_annul),
        .o_stall       (o_stall),
        .o_busy        (o_busy),
        .o_we_hi       (o_we_hi),
        .o_we_lo       (o_we_lo),
        .o_hi          (o_hi),
        .o_lo          (o_lo),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        case (op)
            2'd0: begin
                p = sa * sbv;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd2: begin
                if (b == 0) e.dz = 1'b1;
                else begin
                    e.lo = 32'(sa / sbv);
                    e.hi = 32'(sa % sbv);
                end
            end
            default: begin
                if (b == 0) e.dz = 1'b1;
                else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_we_hi || o_we_lo || o_div_by_zero) begin
            check_eq("we_pair", o_we_hi, o_we_lo);
            check_eq("sb_pending", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("dz_kind", o_div_by_zero, e.dz);
                if (e.dz) begin
                    check_eq("dz_no_we", o_we_hi, 0);
                end else begin
                    check_eq("hi", o_hi, e.hi);
                    check_eq("lo", o_lo, e.lo);
                end
            end
        end else begin
            check_eq("hi_quiet", o_hi, 0);
            check_eq("lo_quiet", o_lo, 0);
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the result cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        int   lat;
        int   exp_st;
        bit   seen;
        e = model(op, a, b);
        sb_q.push_back(e);
        exp_st  = e.dz ? 1 : W + 1;
        i_start = 1'b1;
        i_op    = op;
        i_opa   = a;
        i_opb   = b;
        n    = 0;
        lat  = -1;
        seen = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk);
            if (o_stall) n++;
            if (o_we_hi || o_div_by_zero) begin
                seen = 1'b1;
                lat  = c;
            end
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end
        check_eq("result_seen", seen, 1);
        check_eq("stall_cycles", n, exp_st);
        check_eq("latency", lat, exp_st);
        if (!seen) sb_q.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_op    = 2'd0;
        i_opa   = '0;
        i_opb   = '0;
        i_annul = 1'b0;
        #1;
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_stall", o_stall, 0);
        check_eq("rst_we", {o_we_hi, o_we_lo, o_div_by_zero}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_busy", o_busy, 0);

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(2'd3, 32'd100, 32'd7);
        do_op(2'd2, 32'd5, 32'd0);
        check_eq("dz_idle", o_busy, 0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000);
        do_op(2'd3, 32'd7, 32'd100);

        // Start together with annul in IDLE is ignored.
        i_start = 1'b1;
        i_annul = 1'b1;
        i_op    = 2'd1;
        #1;
        check_eq("annul_idle_stall", o_stall, 0);
        @(posedge clk);
        #1;
        check_eq("annul_idle_busy", o_busy, 0);
        i_start = 1'b0;
        i_annul = 1'b0;

        // Annul at RUN cycle 10 of a DIVU.
        i_start = 1'b1;
        i_op    = 2'd3;
        i_opa   = 32'd1000;
        i_opb   = 32'd3;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        i_annul = 1'b1;
        #1;
        check_eq("annul_run_busy", o_busy, 1);
        check_eq("annul_run_stall", o_stall, 0);
        check_eq("annul_run_we", o_we_hi, 0);
        @(posedge clk);
        #1;
        i_annul = 1'b0;
        check_eq("annul_then_idle", o_busy, 0);
        do_op(2'd1, 32'd123456, 32'd654321);

        // Annul in DZ suppresses the div-by-zero pulse.
        i_start = 1'b1;
        i_op    = 2'd2;
        i_opa   = 32'd9;
        i_opb   = 32'd0;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_annul = 1'b1;
        #1;
        check_eq("annul_dz", o_div_by_zero, 0);
        @(posedge clk);
        #1;
        i_annul = 1'b0;
        check_eq("annul_dz_idle", o_busy, 0);

        // Asynchronous reset in the middle of RUN cycle 5.
        i_start = 1'b1;
        i_op    = 2'd2;
        i_opa   = 32'd77;
        i_opb   = 32'd5;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check_eq("pre_rst_busy", o_busy, 1);
        rst_n   = 1'b0;
        i_start = 1'b1;
        #1;
        check_eq("mid_rst_busy", o_busy, 0);
        check_eq("mid_rst_stall", o_stall, 0);
        check_eq("mid_rst_out", {o_we_hi, o_we_lo, o_div_by_zero, o_hi, o_lo}, 0);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        rst_n   = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_eq("post_rst_idle", o_busy, 0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 1000));
            do_op(2'($urandom_range(0, 3)), ra, rb);
        end

        repeat (2) @(posedge clk);
        #1;
        check_eq("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
